// File: rtl/fir_bus_pkg.sv
// Register map, status bit positions, sequencer states and bus request type for the FIR bus master.
// No logic, so no latency or backpressure applies.
// Shared by the sequencer and its bus-cycle generator.
package fir_bus_pkg;

    localparam logic [2:0] FIR_ADDR_DATA   = 3'd0;
    localparam logic [2:0] FIR_ADDR_STATUS = 3'd1;
    localparam logic [2:0] FIR_ADDR_START  = 3'd5;

    localparam int FIR_STAT_RDY = 0;
    localparam int FIR_STAT_OVF = 15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_START,
        ST_WAIT,
        ST_POLL_RD,
        ST_POLL_HOLD,
        ST_RES_RD,
        ST_RES_HOLD,
        ST_OUT
    } seq_state_t;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/fir_bus_port.sv
// Registered bus-cycle generator: a request shows on the bus the cycle after it is presented.
// Latency: write is 1 cycle; read is READ + HOLD, data valid with rd_done during HOLD.
// Backpressure: none; a read always runs READ then HOLD, requests during READ are ignored.
module fir_bus_port
    import fir_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  bus_req_t    req,
    output logic        rd_done,
    output logic [15:0] rd_dat,
    output logic [2:0]  ioaddr,
    output logic        iocs,
    output logic        iowr,
    output logic        iord,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata
);

    logic hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ioaddr   <= '0;
            iocs     <= 1'b0;
            iowr     <= 1'b0;
            iord     <= 1'b0;
            io_wdata <= '0;
            hold_q   <= 1'b0;
        end else if (iord) begin
            // HOLD keeps chip select and address, drops the strobe
            iocs     <= 1'b1;
            iowr     <= 1'b0;
            iord     <= 1'b0;
            io_wdata <= '0;
            hold_q   <= 1'b1;
        end else begin
            iocs     <= req.wr | req.rd;
            iowr     <= req.wr;
            iord     <= req.rd & ~req.wr;
            ioaddr   <= (req.wr | req.rd) ? req.addr : 3'd0;
            io_wdata <= req.wr ? req.wdata : 16'd0;
            hold_q   <= 1'b0;
        end
    end

    // The caller captures rd_dat on the edge that ends HOLD
    assign rd_done = hold_q;
    assign rd_dat  = io_rdata;

endmodule

// File: rtl/fir_bus_sequencer.sv
// Streams samples through the FIR peripheral: write sample, start, settle, poll RDY, read nout results.
// Latency: first result valid 7+SETTLE cycles after accept, +2 per extra poll, +3 per further result.
// Backpressure: s_ready only in IDLE; m_ready low holds OUT with m_data stable and the bus idle.
module fir_bus_sequencer
    import fir_bus_pkg::*;
#(
    parameter int unsigned SETTLE   = 19,
    parameter int unsigned POLL_MAX = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic [4:0]  nout,
    input  logic [7:0]  coef_base,
    output logic [2:0]  ioaddr,
    output logic        iocs,
    output logic        iowr,
    output logic        iord,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    output logic        busy,
    output logic        ovf,
    output logic        timeout
);

    seq_state_t  state_q, state_d;
    bus_req_t    req;
    logic        rd_done;
    logic [15:0] rd_dat;
    logic        rst_done_q;
    logic [4:0]  nout_q;
    logic [4:0]  res_cnt_q;
    logic [7:0]  settle_q;
    logic [7:0]  poll_q;
    logic        poll_more;

    assign poll_more = ({1'b0, poll_q} + 9'd1) < 9'(POLL_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (s_valid && s_ready) state_d = ST_WR_DATA;
            ST_WR_DATA:   state_d = ST_START;
            ST_START:     state_d = (SETTLE == 0) ? ST_POLL_RD : ST_WAIT;
            ST_WAIT:      if (settle_q == 8'd1) state_d = ST_POLL_RD;
            ST_POLL_RD:   state_d = ST_POLL_HOLD;
            ST_POLL_HOLD: if (rd_done) begin
                if (rd_dat[FIR_STAT_RDY]) state_d = ST_RES_RD;
                else if (poll_more)       state_d = ST_POLL_RD;
                else                      state_d = ST_IDLE;
            end
            ST_RES_RD:    state_d = ST_RES_HOLD;
            ST_RES_HOLD:  if (rd_done) state_d = ST_OUT;
            ST_OUT:       if (m_ready) state_d = (res_cnt_q + 5'd1 == nout_q) ? ST_IDLE : ST_RES_RD;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Bus requests decode the next state so the registered bus lines up with the state
    always_comb begin
        req = '0;
        case (state_d)
            ST_WR_DATA: begin
                req.wr    = 1'b1;
                req.addr  = FIR_ADDR_DATA;
                req.wdata = s_data;
            end
            ST_START: begin
                req.wr    = 1'b1;
                req.addr  = FIR_ADDR_START;
                req.wdata = {8'h00, coef_base};
            end
            ST_POLL_RD: begin
                req.rd   = 1'b1;
                req.addr = FIR_ADDR_STATUS;
            end
            ST_RES_RD: begin
                req.rd   = 1'b1;
                req.addr = FIR_ADDR_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rst_done_q <= 1'b0;
            nout_q     <= '0;
            res_cnt_q  <= '0;
            settle_q   <= '0;
            poll_q     <= '0;
            m_data     <= '0;
            ovf        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (state_q == ST_IDLE && state_d == ST_WR_DATA) begin
                nout_q    <= (nout == 5'd0) ? 5'd1 : nout;
                res_cnt_q <= '0;
            end
            if (state_q == ST_START) begin
                settle_q <= 8'(SETTLE);
                poll_q   <= '0;
            end
            if (state_q == ST_WAIT) settle_q <= settle_q - 8'd1;
            if (state_q == ST_POLL_HOLD && rd_done) begin
                poll_q <= poll_q + 8'd1;
                if (rd_dat[FIR_STAT_OVF]) ovf <= 1'b1;
                if (!rd_dat[FIR_STAT_RDY] && !poll_more) timeout <= 1'b1;
            end
            if (state_q == ST_RES_HOLD && rd_done) m_data <= rd_dat;
            if (state_q == ST_OUT && m_ready) res_cnt_q <= res_cnt_q + 5'd1;
        end
    end

    assign s_ready = rst_done_q && (state_q == ST_IDLE);
    assign busy    = (state_q != ST_IDLE);
    assign m_valid = (state_q == ST_OUT);

    fir_bus_port u_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rd_done  (rd_done),
        .rd_dat   (rd_dat),
        .ioaddr   (ioaddr),
        .iocs     (iocs),
        .iowr     (iowr),
        .iord     (iord),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata)
    );

endmodule

// File: tb/tb_fir_bus_sequencer.sv
// Randomised scoreboard bench with a behavioural FIR peripheral on the I/O bus.
// Expected results are queued at issue time and popped by an independent output monitor.
module tb_fir_bus_sequencer;

    localparam int SETTLE   = 19;
    localparam int POLL_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [4:0]  nout = '0;
    logic [7:0]  coef_base = '0;
    logic [2:0]  ioaddr;
    logic        iocs, iowr, iord;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata = '0;
    logic        busy, ovf, timeout;

    fir_bus_sequencer #(.SETTLE(SETTLE), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .nout(nout), .coef_base(coef_base),
        .ioaddr(ioaddr), .iocs(iocs), .iowr(iowr), .iord(iord), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .busy(busy), .ovf(ovf), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Peripheral result sequence as seen on addr 0 after a start
    function automatic logic [15:0] fir_result(input logic [15:0] smp, input logic [15:0] cf, input int idx);
        logic [15:0] r;
        r = smp + (cf << 4) + 16'(idx * 4099);
        return r;
    endfunction

    // Behavioural peripheral: RDY from poll number cfg_rdy_poll on (0 = never)
    int          cfg_rdy_poll = 1;
    logic        cfg_ovf = 1'b0;
    int          p_polls = 0;
    int          p_idx = 0;
    logic [15:0] p_sample = '0;
    logic [15:0] p_coef = '0;

    always @(posedge clk) begin
        if (iocs && iowr) begin
            if (ioaddr == 3'd0) p_sample <= io_wdata;
            if (ioaddr == 3'd5) begin
                p_coef  <= io_wdata;
                p_polls <= 0;
                p_idx   <= 0;
            end
        end
        if (iocs && iord) begin
            if (ioaddr == 3'd1) begin
                p_polls  <= p_polls + 1;
                io_rdata <= {cfg_ovf, 14'd0, (cfg_rdy_poll != 0 && p_polls + 1 >= cfg_rdy_poll)};
            end else if (ioaddr == 3'd0) begin
                io_rdata <= fir_result(p_sample, p_coef, p_idx);
                p_idx    <= p_idx + 1;
            end
        end
    end

    // Scoreboard monitor
    logic [15:0] exp_q[$];
    int          txn_pops = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("m_data_stable", m_data, prev_data);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h, expected no output", m_data);
                end else begin
                    check("m_data", m_data, exp_q.pop_front());
                end
                txn_pops++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // Bus monitor: per-transaction counts and cycle positions relative to the accept cycle
    int          acc_cyc = 0;
    int          n_wr0, n_wr5, n_stat, n_res, first_wr0, first_wr5, first_stat, first_res, first_mv;
    int          proto_err, sready_err, stall_seen;
    logic [15:0] wr0_dat, wr5_dat;
    logic        pend_rd = 1'b0;
    logic [2:0]  pend_addr = '0;

    task automatic clear_counters();
        n_wr0 = 0; n_wr5 = 0; n_stat = 0; n_res = 0;
        first_wr0 = -1; first_wr5 = -1; first_stat = -1; first_res = -1; first_mv = -1;
        proto_err = 0; sready_err = 0; stall_seen = 0;
        wr0_dat = '0; wr5_dat = '0;
        txn_pops = 0;
    endtask

    always @(negedge clk) begin : bus_mon
        int rel;
        rel = cyc - acc_cyc;
        if (rst_n) begin
            if (pend_rd && !(iocs && !iord && !iowr && ioaddr == pend_addr)) proto_err++;
            pend_rd   = iocs && iord;
            pend_addr = ioaddr;
            if (iowr && iord) proto_err++;
            if (iocs && iowr) begin
                if (ioaddr == 3'd0) begin
                    n_wr0++; wr0_dat = io_wdata;
                    if (first_wr0 < 0) first_wr0 = rel;
                end else if (ioaddr == 3'd5) begin
                    n_wr5++; wr5_dat = io_wdata;
                    if (first_wr5 < 0) first_wr5 = rel;
                end else proto_err++;
            end
            if (iocs && iord) begin
                if (ioaddr == 3'd1) begin
                    n_stat++;
                    if (first_stat < 0) first_stat = rel;
                end else if (ioaddr == 3'd0) begin
                    n_res++;
                    if (first_res < 0) first_res = rel;
                end else proto_err++;
            end
            if (!iocs && (iowr || iord || ioaddr != 3'd0 || io_wdata != 16'd0)) proto_err++;
            if (m_valid && first_mv < 0) first_mv = rel;
            if (m_valid && !m_ready) stall_seen++;
            if (busy && s_ready) sready_err++;
        end else begin
            pend_rd = 1'b0;
        end
    end

    // m_ready driver: always-ready, random, or a planned stall on one result index
    int rdy_mode = 0;
    int stall_idx = -1;
    int stall_left = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_idx >= 0 && m_valid && txn_pops == stall_idx && stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
        end else if (rdy_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
        else m_ready = 1'b1;
    end

    logic [15:0] cur_smp;
    logic [7:0]  cur_cf;
    int          cur_nv, cur_rdyp;
    bit          cur_hold;

    task automatic issue(input logic [15:0] smp, input int nv, input logic [7:0] cf,
                         input int rdyp, input logic ov, input bit hold);
        int n_eff;
        int n;
        cur_smp = smp; cur_nv = nv; cur_cf = cf; cur_rdyp = rdyp; cur_hold = hold;
        cfg_rdy_poll = rdyp;
        cfg_ovf = ov;
        @(posedge clk);
        #1;
        clear_counters();
        n_eff = (nv == 0) ? 1 : nv;
        if (rdyp >= 1 && rdyp <= POLL_MAX)
            for (int k = 0; k < n_eff; k++) exp_q.push_back(fir_result(smp, {8'h00, cf}, k));
        s_data = smp; nout = 5'(nv); coef_base = cf; s_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 100);
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: s_ready 0 after %0d cycles, expected 1", n);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (hold) s_data = ~smp;
        else s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        s_valid = 1'b0;
        if (busy) begin
            checks++; errors++;
            $display("FAIL %s_idle_timeout: busy=1 after %0d cycles, expected 0", name, n);
        end
    endtask

    task automatic verify_txn(input string nm);
        int  n_eff, polls, lat;
        bit  got;
        n_eff = (cur_nv == 0) ? 1 : cur_nv;
        got   = (cur_rdyp >= 1 && cur_rdyp <= POLL_MAX);
        polls = got ? cur_rdyp : POLL_MAX;
        lat   = 2 * (polls - 1);
        check({nm, "_wr0_count"}, n_wr0, 1);
        check({nm, "_wr0_data"}, wr0_dat, cur_smp);
        check({nm, "_wr0_cycle"}, first_wr0, 1);
        check({nm, "_wr5_count"}, n_wr5, 1);
        check({nm, "_wr5_data"}, wr5_dat, {8'h00, cur_cf});
        check({nm, "_wr5_cycle"}, first_wr5, 2);
        check({nm, "_poll_cycle"}, first_stat, 3 + SETTLE);
        check({nm, "_poll_count"}, n_stat, polls);
        check({nm, "_res_count"}, n_res, got ? n_eff : 0);
        check({nm, "_out_count"}, txn_pops, got ? n_eff : 0);
        if (got) begin
            check({nm, "_res_cycle"}, first_res, 5 + SETTLE + lat);
            check({nm, "_mvalid_cycle"}, first_mv, 7 + SETTLE + lat);
        end else begin
            check({nm, "_no_mvalid"}, first_mv, -1);
            check({nm, "_timeout"}, timeout, 1);
        end
        check({nm, "_bus_protocol"}, proto_err, 0);
        check({nm, "_sready_while_busy"}, sready_err, 0);
        check({nm, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic run_txn(input string nm, input logic [15:0] smp, input int nv, input logic [7:0] cf,
                           input int rdyp, input logic ov, input bit hold);
        issue(smp, nv, cf, rdyp, ov, hold);
        wait_idle(nm);
        verify_txn(nm);
    endtask

    initial begin
        clear_counters();
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_strobes", {iocs, iowr, iord}, 0);
        check("rst_ioaddr", ioaddr, 0);
        check("rst_io_wdata", io_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {ovf, timeout}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s_ready_after_release", s_ready, 1);

        rdy_mode = 0;
        run_txn("first_poll", 16'd16384, 1, 8'h3C, 1, 1'b0, 1'b0);
        check("ovf_clear", ovf, 0);

        stall_idx = 1; stall_left = 5;
        run_txn("stall4", 16'($urandom), 4, 8'($urandom), 1, 1'b0, 1'b0);
        check("stall4_stall_cycles", stall_seen, 5);
        stall_idx = -1;

        run_txn("third_poll", 16'($urandom), 2, 8'($urandom), 3, 1'b0, 1'b0);
        check("timeout_clear", timeout, 0);

        run_txn("never_rdy", 16'($urandom), 3, 8'($urandom), 0, 1'b0, 1'b0);
        check("never_rdy_s_ready", s_ready, 1);
        check("never_rdy_ovf", ovf, 0);

        run_txn("busy_ignore", 16'($urandom), 0, 8'($urandom), 2, 1'b0, 1'b1);

        rdy_mode = 1;
        run_txn("nout16", 16'($urandom), 16, 8'($urandom), 1, 1'b0, 1'b0);

        run_txn("ovf_set", 16'($urandom), 2, 8'($urandom), 1, 1'b1, 1'b0);
        check("ovf_set_flag", ovf, 1);
        run_txn("ovf_keep", 16'($urandom), 1, 8'($urandom), 2, 1'b0, 1'b0);
        check("ovf_sticky", ovf, 1);
        check("timeout_sticky", timeout, 1);

        for (int t = 0; t < 12; t++)
            run_txn($sformatf("rand%0d", t), 16'($urandom), $urandom_range(0, 16), 8'($urandom),
                    $urandom_range(0, 5), 1'b0, bit'($urandom_range(0, 1)));

        // Reset in the middle of the settle wait
        rdy_mode = 0;
        issue(16'($urandom), 2, 8'($urandom), 1, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("mid_wait_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_wait_rst_strobes", {iocs, iowr, iord}, 0);
        check("mid_wait_rst_busy", busy, 0);
        check("mid_wait_rst_flags", {ovf, timeout}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counters();
        repeat (40) @(negedge clk);
        check("no_reissue_bus", n_wr0 + n_wr5 + n_stat + n_res, 0);
        check("no_reissue_mvalid", first_mv, -1);

        // Reset during the sample write cycle
        issue(16'($urandom), 1, 8'($urandom), 1, 1'b0, 1'b0);
        check("mid_write_iowr", iowr, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_write_rst_strobes", {iocs, iowr, iord}, 0);
        check("mid_write_rst_wdata", io_wdata, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_txn("after_reset", 16'($urandom), 3, 8'($urandom), 2, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
